// File: rtl/rgb_pkg.sv
// Shared constants and types for the RGB LED data serializer.
// The upstream byte source walks BYTES_PER_FRAME bytes per frame (16 LEDs x G/R/B).
package rgb_pkg;

  localparam int unsigned DATA_W          = 8;
  localparam int unsigned BYTES_PER_FRAME = 48;
  localparam int unsigned BITCNT_W        = 3;

  typedef logic [BITCNT_W-1:0] bitcnt_t;

  // True when cnt indexes the final bit slot of a data_w-bit byte.
  function automatic logic is_last_bit(bitcnt_t cnt, int unsigned data_w);
    return cnt == bitcnt_t'(data_w - 1);
  endfunction

endpackage

// File: rtl/rgb_step_detect.sv
// Registered rising-edge detector on nextflag; one step per 0->1 transition.
// The history register keeps tracking nextflag through reset so a level held across release is not a step.
module rgb_step_detect (
  input  logic clk,
  input  logic reset,
  input  logic nextflag,
  output logic step
);

  logic nf_q;

  always_ff @(posedge clk) begin
    nf_q <= nextflag;
  end

  assign step = nextflag & ~nf_q & ~reset;

endmodule

// File: rtl/rgb_data_tx.sv
// Byte-to-bit serializer: each step emits the next bit of the current colour byte, MSB first,
// and flags endevent with the last bit so the source can advance.
module rgb_data_tx #(
  parameter int unsigned DATA_W = rgb_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              nextflag,
  input  logic [DATA_W-1:0] data,
  output logic              outstat,
  output logic              endevent
);

  import rgb_pkg::*;

  logic              step;
  bitcnt_t           bitcnt_q, bitcnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              outstat_q, outstat_d;
  logic              endevent_q, endevent_d;

  rgb_step_detect u_step_detect (
    .clk      (clk),
    .reset    (reset),
    .nextflag (nextflag),
    .step     (step)
  );

  always_comb begin
    bitcnt_d   = bitcnt_q;
    shreg_d    = shreg_q;
    outstat_d  = outstat_q;
    endevent_d = endevent_q;
    if (step) begin
      if (bitcnt_q == '0) begin
        // Load step: data is sampled only here, so mid-byte changes are ignored.
        outstat_d  = data[DATA_W-1];
        shreg_d    = {data[DATA_W-2:0], 1'b0};
        endevent_d = 1'b0;
        bitcnt_d   = bitcnt_t'(1);
      end else if (is_last_bit(bitcnt_q, DATA_W)) begin
        outstat_d  = shreg_q[DATA_W-1];
        endevent_d = 1'b1;
        bitcnt_d   = '0;
      end else begin
        outstat_d  = shreg_q[DATA_W-1];
        shreg_d    = shreg_q << 1;
        bitcnt_d   = bitcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bitcnt_q   <= '0;
      shreg_q    <= '0;
      outstat_q  <= 1'b0;
      endevent_q <= 1'b0;
    end else begin
      bitcnt_q   <= bitcnt_d;
      shreg_q    <= shreg_d;
      outstat_q  <= outstat_d;
      endevent_q <= endevent_d;
    end
  end

  assign outstat  = outstat_q;
  assign endevent = endevent_q;

endmodule

// File: tb/tb_rgb_data_tx.sv
// Self-checking bench for rgb_data_tx: directed vector table, hand sequences for corner cases,
// and a randomized cycle-by-cycle run against a bit-index reference model.
module tb_rgb_data_tx;

  logic       clk;
  logic       reset;
  logic       nextflag;
  logic [7:0] data;
  logic       outstat;
  logic       endevent;

  int total;
  int bad;

  rgb_data_tx #(.DATA_W(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .nextflag (nextflag),
    .data     (data),
    .outstat  (outstat),
    .endevent (endevent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] din;
    logic [7:0] exp_bits;  // expected outstat per step, step 1 in bit 7
    logic [7:0] exp_end;   // expected endevent per step, step 1 in bit 7
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string nm, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
    end
  endtask

  // Entered and left at a negedge; one nextflag pulse, outputs checked one cycle later.
  task automatic do_step(input logic eo, input logic ee, input string nm);
    nextflag = 1'b1;
    @(negedge clk);
    check({nm, " outstat"}, outstat, eo);
    check({nm, " endevent"}, endevent, ee);
    nextflag = 1'b0;
    @(negedge clk);
  endtask

  // Reference model state: which bit of the latched byte goes out next.
  logic [7:0] m_byte;
  int         m_idx;
  logic       m_out;
  logic       m_end;
  logic       m_prev;

  initial begin
    total    = 0;
    bad      = 0;
    reset    = 1'b1;
    nextflag = 1'b0;
    data     = 8'h00;

    vecs[0] = '{din: 8'h05, exp_bits: 8'b0000_0101, exp_end: 8'b0000_0001};
    vecs[1] = '{din: 8'h02, exp_bits: 8'b0000_0010, exp_end: 8'b0000_0001};
    vecs[2] = '{din: 8'hC3, exp_bits: 8'b1100_0011, exp_end: 8'b0000_0001};
    vecs[3] = '{din: 8'h96, exp_bits: 8'b1001_0110, exp_end: 8'b0000_0001};

    // Reset with nextflag toggling, then release while nextflag is already high.
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      nextflag = ~nextflag;
      @(negedge clk);
      check("rst outstat", outstat, 1'b0);
      check("rst endevent", endevent, 1'b0);
    end
    nextflag = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("release outstat", outstat, 1'b0);
      check("release endevent", endevent, 1'b0);
    end
    nextflag = 1'b0;
    @(negedge clk);

    // Table: back-to-back bytes, data switched right at the endevent rise.
    for (int v = 0; v < 4; v++) begin
      data = vecs[v].din;
      for (int s = 0; s < 8; s++) begin
        do_step(vecs[v].exp_bits[7-s], vecs[v].exp_end[7-s], $sformatf("vec%0d step%0d", v, s + 1));
      end
      repeat (3) begin
        @(negedge clk);
        check("endevent hold", endevent, 1'b1);
        check("outstat hold", outstat, vecs[v].exp_bits[0]);
      end
    end

    // Mid-byte data change is ignored.
    data = 8'hFF;
    for (int s = 0; s < 3; s++) do_step(1'b1, 1'b0, "ff head");
    data = 8'h00;
    for (int s = 0; s < 5; s++) do_step(1'b1, s == 4, "ff tail");

    // Reset mid-byte discards the partial byte.
    data = 8'hA5;
    do_step(1'b1, 1'b0, "a5 b1");
    do_step(1'b0, 1'b0, "a5 b2");
    do_step(1'b1, 1'b0, "a5 b3");
    do_step(1'b0, 1'b0, "a5 b4");
    reset = 1'b1;
    @(negedge clk);
    check("midrst outstat", outstat, 1'b0);
    check("midrst endevent", endevent, 1'b0);
    reset = 1'b0;
    data  = 8'h3C;
    for (int s = 0; s < 8; s++) begin
      logic [7:0] pat;
      pat = 8'b0011_1100;
      do_step(pat[7-s], s == 7, $sformatf("3c step%0d", s + 1));
    end

    // Long nextflag high counts as a single step.
    data     = 8'hA0;
    nextflag = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("long outstat", outstat, 1'b1);
      check("long endevent", endevent, 1'b0);
    end
    nextflag = 1'b0;
    @(negedge clk);
    do_step(1'b0, 1'b0, "after long b2");
    do_step(1'b1, 1'b0, "after long b3");

    // Randomized run against the reference model.
    reset    = 1'b1;
    nextflag = 1'b0;
    @(negedge clk);
    reset  = 1'b0;
    m_idx  = 0;
    m_byte = 8'h00;
    m_out  = 1'b0;
    m_end  = 1'b0;
    m_prev = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      logic stp;
      check("rand outstat", outstat, m_out);
      check("rand endevent", endevent, m_end);
      reset    = ($urandom_range(0, 99) == 0);
      nextflag = ($urandom_range(0, 2) != 0);
      data     = 8'($urandom);
      stp      = nextflag & ~m_prev & ~reset;
      m_prev   = nextflag;
      if (reset) begin
        m_idx = 0;
        m_out = 1'b0;
        m_end = 1'b0;
      end else if (stp) begin
        if (m_idx == 0) m_byte = data;
        m_out = m_byte[7-m_idx];
        m_end = (m_idx == 7);
        m_idx = (m_idx + 1) % 8;
      end
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rgb_data_tx.md
# rgb_data_tx

Byte-to-bit serializer for the RGB LED driver chain. An upstream bit-timing generator raises `nextflag` once per LED bit slot. On each step the block presents the next bit of the current colour byte on `outstat`, MSB first. After the 8th bit it raises `endevent` so the upstream byte source advances to the next colour byte. The source wraps after 48 bytes, i.e. 16 LEDs × G/R/B.

## Interface
- `DATA_W`, default 8: bits per colour byte.
- `clk`  in  1: single system clock; all state updates on its rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `nextflag`  in  1: bit-advance request, synchronous to `clk`. Each 0→1 transition is one step.
- `data`  in  DATA_W: current colour byte from the source. Held stable from the `endevent` rise until the first step of the next byte.
- `outstat`  out  1: serial bit currently being emitted.
- `endevent`  out  1: byte-complete flag. High from the 8th step of a byte until the next step.

## Operation
- Edge detect:
  - `nf_q` holds the previous-cycle `nextflag`.
  - `step = nextflag & ~nf_q`.
  - During reset, `nf_q` loads `nextflag`, so a high level at reset release does not produce a step.
- State:
  - `shreg[DATA_W-1:0]`.
  - `bitcnt[2:0]` counts bits already emitted from the current byte, 0..7.
- Reset values:
  - `outstat` = 0, `endevent` = 0, `bitcnt` = 0, `shreg` = 0.
  - No steps are processed while `reset` = 1.
- On `step` with `bitcnt` = 0 (byte load):
  - `outstat` ← `data[7]`, `shreg` ← {`data[6:0]`, 0}.
  - `endevent` ← 0, `bitcnt` ← 1.
- On `step` with `bitcnt` = 1..6:
  - `outstat` ← `shreg[7]`, `shreg` ← `shreg` << 1.
  - `bitcnt` ← `bitcnt`+1.
- On `step` with `bitcnt` = 7 (last bit):
  - `outstat` ← `shreg[7]`, `endevent` ← 1.
  - `bitcnt` ← 0 (wraps).
- No step: all registers hold.
- `data` is sampled only on the load step. Changes to `data` mid-byte have no effect on the bits being emitted.
- There is no idle state. After the last bit, the next step immediately loads the next byte (back-to-back bytes).

## Timing
- Latency:
  - `nextflag` is sampled high at clk edge k, with `nf_q` = 0.
  - `outstat` and `endevent` update at edge k and are visible in cycle k+1.
- Each byte takes exactly 8 steps.
- `endevent` rises together with the 8th bit. It falls together with the 1st bit of the next byte.
- The source has at least one clk cycle, plus the remaining nextflag period, to update `data` before the next load.
- `nextflag` held high for many cycles counts as one step. The next step needs a low period of at least 1 clk.
- Reset asserted mid-byte:
  - At the next edge all state returns to reset values and the partial byte is discarded.
  - The first step after release loads a fresh byte.
- Reset and a `nextflag` rise in the same cycle: reset wins and no step occurs.

## Structure
- Shared package `rgb_pkg`:
  - `DATA_W` = 8.
  - `BYTES_PER_FRAME` = 48, used by the upstream byte source.
  - Bit-counter width constant `BITCNT_W` = 3.
- One natural sub-module, `rgb_step_detect`: registered rising-edge detector on `nextflag` with synchronous reset. Outputs `step`.
- The rest (shift register, counter, flags) lives in `rgb_data_tx`.

## Test plan
- Reset: assert `reset` for 2 cycles with `nextflag` toggling → `outstat` = 0, `endevent` = 0 throughout. No step occurs after release if `nextflag` is already high.
- Single byte: `data` = 8'h05, 8 steps → `outstat` sequence 0,0,0,0,0,1,0,1. `endevent` goes high exactly on step 8 and stays high.
- Back-to-back: on the `endevent` rise, change `data` to 8'h02, then issue 8 steps. Expect:
  - `endevent` falls on step 1.
  - `outstat` = 0,0,0,0,0,0,1,0.
  - `endevent` rises again on step 8.
- Mid-byte data change: load 8'hFF, change `data` to 8'h00 after step 3 → remaining bits are all 1.
- Reset mid-byte: assert after 4 steps of 8'hA5 → outputs return to 0. Next 8 steps with 8'h3C give 0,0,1,1,1,1,0,0 and `endevent` on step 8.
- Long `nextflag` high for 20 cycles → exactly one bit advance.
